// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: frame states and constants shared by the UART receive controller
package uart_rx_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;
    localparam int PRESCALE_MIN = 6;
endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: serial line, frame config, datapath strobes and per-frame status
interface uart_rx_ctrl_if #(parameter int PRESCALE_WIDTH = 4);
    logic s_data_in;
    logic [PRESCALE_WIDTH-1:0] prescale_in;
    logic par_en_in;
    logic par_err_in;
    logic sampled_bit_out;
    logic deser_en_out;
    logic par_chk_en_out;
    logic busy_out;
    logic data_valid_out;
    logic parity_error_out;
    logic stop_error_out;
    modport master (
        output s_data_in, prescale_in, par_en_in, par_err_in,
        input  sampled_bit_out, deser_en_out, par_chk_en_out, busy_out,
               data_valid_out, parity_error_out, stop_error_out
    );
    modport slave (
        input  s_data_in, prescale_in, par_en_in, par_err_in,
        output sampled_bit_out, deser_en_out, par_chk_en_out, busy_out,
               data_valid_out, parity_error_out, stop_error_out
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: three mid-bit captures of the serial line and their majority vote
module uart_rx_sampler #(
    parameter int PRESCALE_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      res_n,
    input  logic                      s_data_in,
    input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
    input  logic [PRESCALE_WIDTH-1:0] pe,
    output logic                      sampled_bit
);
    logic [2:0] cap_q, cap_d;
    logic [PRESCALE_WIDTH-1:0] mid;
    always_comb begin
        mid = pe >> 1;
        cap_d[0] = (edge_cnt == mid - PRESCALE_WIDTH'(1)) ? s_data_in : cap_q[0];
        cap_d[1] = (edge_cnt == mid) ? s_data_in : cap_q[1];
        cap_d[2] = (edge_cnt == mid + PRESCALE_WIDTH'(1)) ? s_data_in : cap_q[2];
    end
    always_ff @(posedge clk) begin
        if (!res_n) cap_q <= '0;
        else cap_q <= cap_d;
    end
    assign sampled_bit = (cap_q[0] & cap_q[1]) | (cap_q[0] & cap_q[2]) | (cap_q[1] & cap_q[2]);
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame sequencer driving the deserializer and parity checker
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 4
) (
    input logic           clk,
    input logic           res_n,
    uart_rx_ctrl_if.slave rx
);
    localparam int BW = $clog2(DATA_WIDTH + 3);
    localparam logic [PRESCALE_WIDTH-1:0] PMIN = PRESCALE_WIDTH'(PRESCALE_MIN);
    rx_state_e state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d, pe_q, pe_d, pe_even, mid;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic par_en_q, par_en_d, par_err_q, par_err_d;
    logic sb_q, sb_d, deser_q, deser_d, chk_q, chk_d;
    logic dv_q, dv_d, perr_q, perr_d, serr_q, serr_d;
    logic sampled_bit, start, wrap, done, stop_done;
    uart_rx_sampler #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_sampler (
        .clk        (clk),
        .res_n      (res_n),
        .s_data_in  (rx.s_data_in),
        .edge_cnt   (edge_cnt_q),
        .pe         (pe_q),
        .sampled_bit(sampled_bit)
    );
    always_comb begin
        pe_even    = rx.prescale_in & ~PRESCALE_WIDTH'(1);
        mid        = pe_q >> 1;
        start      = state_q == IDLE && !rx.s_data_in;
        wrap       = edge_cnt_q == pe_q - PRESCALE_WIDTH'(1);
        done       = edge_cnt_q == mid + PRESCALE_WIDTH'(2);
        stop_done  = state_q == STOP && done;
        edge_cnt_d = (state_q == IDLE || wrap) ? '0 : edge_cnt_q + PRESCALE_WIDTH'(1);
        bit_cnt_d  = state_q == IDLE ? '0 : bit_cnt_q + BW'(wrap);
        pe_d       = start ? (pe_even < PMIN ? PMIN : pe_even) : pe_q;
        par_en_d   = start ? rx.par_en_in : par_en_q;
        par_err_d  = start ? 1'b0 : chk_q ? rx.par_err_in : par_err_q;
        sb_d       = (done && state_q != IDLE) ? sampled_bit : sb_q;
        deser_d    = state_q == DATA && done;
        chk_d      = state_q == PARITY && done;
        serr_d     = stop_done && !sampled_bit;
        perr_d     = stop_done && par_err_q;
        dv_d       = stop_done && sampled_bit && !par_err_q;
        state_d    = state_q;
        case (state_q)
            IDLE:    state_d = start ? START : IDLE;
            START:   state_d = (done && sampled_bit) ? IDLE : wrap ? DATA : START;
            DATA:    state_d = (wrap && bit_cnt_q == BW'(DATA_WIDTH)) ? (par_en_q ? PARITY : STOP) : DATA;
            PARITY:  state_d = wrap ? STOP : PARITY;
            // leave STOP in the cycle the status pulse is visible, freeing the line for the next frame
            STOP:    state_d = (dv_q || perr_q || serr_q) ? IDLE : STOP;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_q    <= IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            pe_q       <= PMIN;
            par_en_q   <= 1'b0;
            par_err_q  <= 1'b0;
            sb_q       <= 1'b0;
            deser_q    <= 1'b0;
            chk_q      <= 1'b0;
            dv_q       <= 1'b0;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            pe_q       <= pe_d;
            par_en_q   <= par_en_d;
            par_err_q  <= par_err_d;
            sb_q       <= sb_d;
            deser_q    <= deser_d;
            chk_q      <= chk_d;
            dv_q       <= dv_d;
            perr_q     <= perr_d;
            serr_q     <= serr_d;
        end
    end
    assign rx.sampled_bit_out  = sb_q;
    assign rx.deser_en_out     = deser_q;
    assign rx.par_chk_en_out   = chk_q;
    assign rx.busy_out         = state_q != IDLE;
    assign rx.data_valid_out   = dv_q;
    assign rx.parity_error_out = perr_q;
    assign rx.stop_error_out   = serr_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed frames against hand-computed strobe and status cycles
module tb_uart_rx_ctrl;
    logic clk = 1'b0;
    logic res_n = 1'b0;
    int n_chk = 0, n_pass = 0;
    int n_deser, first_deser, n_par, par_cyc, dv_cyc, dv_last, dv_n, pe_cyc, se_cyc, busy_low, st_n, zero_rst;
    logic [7:0] bits;
    uart_rx_ctrl_if #(.PRESCALE_WIDTH(4)) d ();
    uart_rx_ctrl #(.DATA_WIDTH(8), .PRESCALE_WIDTH(4)) dut (
        .clk  (clk),
        .res_n(res_n),
        .rx   (d)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask
    function automatic logic fbit(input logic [7:0] dat, input logic pen, input logic pbit,
                                  input logic sbit, input int pe, input int r);
        int k;
        k = (r == 0) ? 0 : (r - 1) / pe;
        if (k == 0) return 1'b0;
        if (k <= 8) return dat[k-1];
        if (k == 9 && pen) return pbit;
        if (k == 9 + int'(pen)) return sbit;
        return 1'b1;
    endfunction
    function automatic int outs();
        return int'({d.busy_out, d.deser_en_out, d.par_chk_en_out, d.data_valid_out,
                     d.parity_error_out, d.stop_error_out, d.sampled_bit_out});
    endfunction
    // cycle t observed at the negedge before edge t; line value for edge t driven right after
    task automatic run(input logic [7:0] d0, input logic [7:0] d1, input logic two, input logic pen,
                       input logic pbit, input logic perr, input logic sbit, input logic [3:0] psc,
                       input int pe, input int spike_t, input int rst_t, input logic glitch,
                       input logic chg, input int ncyc);
        n_deser = 0; first_deser = -1; n_par = 0; par_cyc = -1; dv_cyc = -1; dv_last = -1;
        dv_n = 0; pe_cyc = -1; se_cyc = -1; busy_low = -1; st_n = 0; zero_rst = -1; bits = '0;
        d.prescale_in = psc;
        d.par_en_in = pen;
        for (int t = 0; t < ncyc; t++) begin
            @(negedge clk);
            if (t > 0) begin
                if (d.deser_en_out) begin
                    n_deser++;
                    bits = {d.sampled_bit_out, bits[7:1]};
                    if (first_deser < 0) first_deser = t;
                end
                if (d.par_chk_en_out) begin n_par++; par_cyc = t; end
                if (d.data_valid_out) begin dv_n++; dv_last = t; if (dv_cyc < 0) dv_cyc = t; end
                if (d.parity_error_out && pe_cyc < 0) pe_cyc = t;
                if (d.stop_error_out && se_cyc < 0) se_cyc = t;
                if (d.data_valid_out || d.parity_error_out || d.stop_error_out) st_n++;
                if (!d.busy_out && busy_low < 0) busy_low = t;
                if (t == rst_t + 1) zero_rst = outs();
            end
            res_n = (t != rst_t);
            d.par_err_in = d.par_chk_en_out ? perr : 1'b0;
            if (chg && t == 10) begin d.prescale_in = 4'd12; d.par_en_in = 1'b1; end
            if (glitch) d.s_data_in = (t >= 2);
            else if (rst_t >= 0 && t >= rst_t) d.s_data_in = 1'b1;
            else if (t == spike_t) d.s_data_in = 1'b0;
            else if (two && t >= 81) d.s_data_in = fbit(d1, pen, pbit, sbit, pe, t - 81);
            else d.s_data_in = fbit(d0, pen, pbit, sbit, pe, t);
        end
        d.s_data_in = 1'b1;
        d.par_err_in = 1'b0;
        res_n = 1'b1;
    endtask
    initial begin
        d.s_data_in = 1'b1; d.prescale_in = 4'd8; d.par_en_in = 1'b0; d.par_err_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", outs(), 0);
        res_n = 1'b1;
        repeat (2) @(negedge clk);
        run(8'hA5, 8'h00, 0, 0, 0, 0, 1, 4'd8, 8, -1, -1, 0, 0, 100);
        chk("a5_deser_count", n_deser, 8);
        chk("a5_bits", int'(bits), 'hA5);
        chk("a5_first_deser", first_deser, 16);
        chk("a5_dv_cycle", dv_cyc, 80);
        chk("a5_dv_count", dv_n, 1);
        chk("a5_parity_err", pe_cyc, -1);
        chk("a5_stop_err", se_cyc, -1);
        chk("a5_busy_low", busy_low, 81);
        chk("a5_par_chk_count", n_par, 0);
        run(8'h3C, 8'h00, 0, 1, 0, 1, 1, 4'd8, 8, -1, -1, 0, 0, 100);
        chk("3c_parity_err_cycle", pe_cyc, 88);
        chk("3c_dv_absent", dv_cyc, -1);
        chk("3c_par_chk_cycle", par_cyc, 80);
        chk("3c_bits", int'(bits), 'h3C);
        chk("3c_stop_err", se_cyc, -1);
        run(8'h3C, 8'h00, 0, 1, 0, 0, 1, 4'd8, 8, -1, -1, 0, 0, 100);
        chk("3c_ok_dv_cycle", dv_cyc, 88);
        chk("3c_ok_parity_err", pe_cyc, -1);
        run(8'hA5, 8'h00, 0, 0, 0, 0, 0, 4'd8, 8, -1, -1, 0, 0, 100);
        chk("stop0_err_cycle", se_cyc, 80);
        chk("stop0_dv_absent", dv_cyc, -1);
        chk("stop0_busy_low", busy_low, 81);
        chk("stop0_parity_err", pe_cyc, -1);
        run(8'h00, 8'h00, 0, 0, 0, 0, 1, 4'd8, 8, -1, -1, 1, 0, 30);
        chk("glitch_busy_low", busy_low, 8);
        chk("glitch_deser", n_deser, 0);
        chk("glitch_status", st_n, 0);
        run(8'hA5, 8'h00, 0, 0, 0, 0, 1, 4'd8, 8, 13, -1, 0, 1, 100);
        chk("spike_bits", int'(bits), 'hA5);
        chk("spike_dv_cycle", dv_cyc, 80);
        chk("latched_cfg_par_chk", n_par, 0);
        run(8'hFF, 8'h00, 0, 0, 0, 0, 1, 4'd8, 8, -1, 27, 0, 0, 60);
        chk("reset_mid_outputs", zero_rst, 0);
        chk("reset_mid_busy_low", busy_low, 28);
        chk("reset_mid_status", st_n, 0);
        run(8'hC3, 8'h00, 0, 0, 0, 0, 1, 4'd5, 6, -1, -1, 0, 0, 80);
        chk("p5_dv_cycle", dv_cyc, 61);
        chk("p5_first_deser", first_deser, 13);
        chk("p5_bits", int'(bits), 'hC3);
        run(8'hC3, 8'h00, 0, 0, 0, 0, 1, 4'd6, 6, -1, -1, 0, 0, 80);
        chk("p6_dv_cycle", dv_cyc, 61);
        run(8'h96, 8'h00, 0, 0, 0, 0, 1, 4'd3, 6, -1, -1, 0, 0, 80);
        chk("p3_dv_cycle", dv_cyc, 61);
        chk("p3_bits", int'(bits), 'h96);
        run(8'hA5, 8'h5A, 1, 0, 0, 0, 1, 4'd8, 8, -1, -1, 0, 0, 190);
        chk("b2b_dv_count", dv_n, 2);
        chk("b2b_dv_first", dv_cyc, 80);
        chk("b2b_dv_second", dv_last, 161);
        chk("b2b_deser_count", n_deser, 16);
        chk("b2b_bits", int'(bits), 'h5A);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
